lp_escape_rx: RTL and testbench
===============================

LP_ESCAPE_RX -- requirements
Module: lp_escape_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flop count on i_lp_p/i_lp_n, legal range 2..3.
REQ-002 Parameter FILT_CYC, default 4: number of consecutive identical synchronized samples needed to accept a new line state, legal range 1..15.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 i_CLK_100MHZ  in  1  sole clock for all logic.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_lp_p / i_lp_n  in  1 each  asynchronous LP line levels (Dp, Dn).
REQ-007 o_lp_state  out  2  filtered line state {p,n}.
REQ-008 o_stop  out  1  high while the FSM is in STOP.
REQ-009 o_hs_req  out  1  one-cycle pulse when an HS request sequence completes.
REQ-010 o_lpdt  out  1  high while in LPDT.
REQ-011 o_ulps  out  1  high while in ULPS.
REQ-012 o_byte  out  8  received LPDT byte; valid only with o_byte_valid.
REQ-013 o_byte_valid  out  1  one-cycle pulse per received byte.
REQ-014 o_trigger  out  1  one-cycle pulse; o_trig_code  out  8  holds the code until the next trigger.
REQ-015 o_eot  out  1  one-cycle pulse on a clean escape exit.
REQ-016 o_err_esc / o_err_sync / o_err_ctrl  out  1 each  one-cycle error pulses.

Function
REQ-017 The synchronizer and filter SHALL update o_lp_state only after FILT_CYC consecutive identical synchronized samples that differ from the current value; the filter counter SHALL clear on any sample mismatch.
REQ-018 The FSM SHALL act only on o_lp_state changes.
REQ-019 FSM states: STOP, HS_RQST, LP_RQST, LP_YIELD, ESC_RQST, ESC_GO, CMD, LPDT, ULPS, TRIG_WAIT, ERR_WAIT.
REQ-020 HS request path: STOP -01-> HS_RQST -00-> pulse o_hs_req, then wait in ERR_WAIT (no error pulse) until 11.
REQ-021 Escape entry path: STOP -10-> LP_RQST -00-> LP_YIELD -01-> ESC_RQST -00-> ESC_GO/CMD.
REQ-022 Any other transition out of STOP, LP_RQST, LP_YIELD, ESC_RQST or HS_RQST SHALL pulse o_err_ctrl and enter ERR_WAIT, except a transition to 11, which SHALL return to STOP silently.
REQ-023 Bit decoding in CMD/LPDT uses spaced one-hot: 10 = mark-1, 01 = mark-0, 00 = space.
REQ-024 A bit SHALL be shifted in LSB-first on the space that follows a mark.
REQ-025 A 3-bit bit counter SHALL wrap 7->0 on each completed byte.
REQ-026 A direct 01<->10 transition, or a space-to-space event, SHALL pulse o_err_ctrl and enter ERR_WAIT.
REQ-027 CMD byte 0xE1 SHALL enter LPDT.
REQ-028 CMD byte 0x1E SHALL enter ULPS.
REQ-029 CMD bytes 0x62, 0x5D, 0x21 and 0xA0 SHALL load o_trig_code, pulse o_trigger, and enter TRIG_WAIT.
REQ-030 Any other CMD byte SHALL pulse o_err_esc and enter ERR_WAIT.
REQ-031 In LPDT, o_byte and o_byte_valid SHALL assert in the cycle after o_lp_state becomes 00 following the 8th mark.
REQ-032 Exit from CMD/LPDT/ULPS/TRIG_WAIT is mark-then-11. In CMD/LPDT, a bit counter of 0 on exit SHALL pulse o_eot and go to STOP.
REQ-033 If the bit counter is nonzero on exit, the block SHALL pulse o_err_sync, discard the partial byte, and not pulse o_eot.
REQ-034 ULPS and TRIG_WAIT SHALL ignore all states except 11; on 11 they SHALL pulse o_eot and go to STOP.
REQ-035 ERR_WAIT SHALL go to STOP on 11 with no pulse.
REQ-036 No two pulse outputs SHALL assert in the same cycle except o_err_sync with nothing else.

Reset
REQ-037 Synchronizer flops and o_lp_state SHALL reset to 2'b11.
REQ-038 The filter counter, bit counter and shift register SHALL reset to 0.
REQ-039 The FSM SHALL reset to STOP.
REQ-040 o_stop SHALL reset to 1; all other outputs, including o_byte and o_trig_code, SHALL reset to 0.
REQ-041 A reset mid-LPDT SHALL abort with no o_eot, and a subsequent line at 00 SHALL be flagged by REQ-022.

Structure
REQ-042 Line-state encodings (LP11, LP10, LP01, LP00), FSM state encodings, and command codes (0xE1, 0x1E, 0x62, 0x5D, 0x21, 0xA0) SHALL live in the shared package lp_pkg.
REQ-043 The synchronizer plus glitch filter SHALL be one sub-module, lp_line_filter, instantiated once for the 2-bit line.

Verification
REQ-044 Entry sequence 11,10,00,01,00, then 0xE1, then bytes 0xA5 and 0x3C, then mark-1 and 11 -> o_lpdt high; two o_byte_valid pulses with 0xA5 then 0x3C; one o_eot; no errors.
REQ-045 Entry sequence, then 0x1E, then 500 cycles of 00, then 10 and 11 -> o_ulps high throughout the 00 period; o_eot on exit; o_stop=1 afterwards.
REQ-046 Entry sequence, then 0x62, then exit -> o_trigger with o_trig_code=0x62; then send 0x55 as CMD -> o_err_esc and ERR_WAIT until 11.
REQ-047 LPDT with 3 bits sent, then mark and 11 -> o_err_sync, no o_byte_valid, no o_eot.
REQ-048 Glitches of FILT_CYC-1 cycles to 00 while in STOP -> o_lp_state stays 11; 11,01,00 -> o_hs_req pulse exactly once.
REQ-049 i_reset asserted mid-LPDT with the line held at 00 -> o_stop=1 in the cycle after reset; after filter latency, o_err_ctrl pulse and ERR_WAIT.

Source files
------------

// File: rtl/lp_pkg.sv
// rtl/lp_pkg.sv - shared line-state, FSM-state and escape command encodings
package lp_pkg;

    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP10 = 2'b10;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    localparam logic [3:0] ST_STOP      = 4'd0;
    localparam logic [3:0] ST_HS_RQST   = 4'd1;
    localparam logic [3:0] ST_LP_RQST   = 4'd2;
    localparam logic [3:0] ST_LP_YIELD  = 4'd3;
    localparam logic [3:0] ST_ESC_RQST  = 4'd4;
    localparam logic [3:0] ST_ESC_GO    = 4'd5;
    localparam logic [3:0] ST_CMD       = 4'd6;
    localparam logic [3:0] ST_LPDT      = 4'd7;
    localparam logic [3:0] ST_ULPS      = 4'd8;
    localparam logic [3:0] ST_TRIG_WAIT = 4'd9;
    localparam logic [3:0] ST_ERR_WAIT  = 4'd10;

    localparam logic [7:0] CMD_LPDT  = 8'hE1;
    localparam logic [7:0] CMD_ULPS  = 8'h1E;
    localparam logic [7:0] CMD_TRIG0 = 8'h62;
    localparam logic [7:0] CMD_TRIG1 = 8'h5D;
    localparam logic [7:0] CMD_TRIG2 = 8'h21;
    localparam logic [7:0] CMD_TRIG3 = 8'hA0;

    function automatic logic is_trigger(input logic [7:0] code);
        return (code == CMD_TRIG0) || (code == CMD_TRIG1) ||
               (code == CMD_TRIG2) || (code == CMD_TRIG3);
    endfunction

endpackage

// File: rtl/lp_line_filter.sv
// rtl/lp_line_filter.sv - 2-bit LP line synchronizer and glitch filter
module lp_line_filter
    import lp_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] line,
    output logic [1:0] state
);

    localparam logic [3:0] FILT_LEN = 4'(FILT_CYC);

    logic [SYNC_STAGES-1:0][1:0] sync_q;
    logic [1:0]                  sample;
    logic [1:0]                  cand;
    logic [3:0]                  cnt;
    logic [3:0]                  run_len;

    assign sample = sync_q[SYNC_STAGES-1];

    // Length of the current run of identical samples, including this one
    always_comb begin
        run_len = (sample == cand) ? cnt + 4'd1 : 4'd1;
    end

    // Metastability chain; idle line level is 11
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{LP11}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line};
        end
    end

    // Accept a new line state only after a long enough stable run
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LP11;
            cand  <= LP11;
            cnt   <= '0;
        end else begin
            cand <= sample;
            if (sample == state) begin
                cnt <= '0;
            end else if (run_len >= FILT_LEN) begin
                state <= sample;
                cnt   <= '0;
            end else begin
                cnt <= run_len;
            end
        end
    end

endmodule

// File: rtl/lp_escape_rx.sv
// rtl/lp_escape_rx.sv - LP escape-mode receiver: request sequences, command, LPDT and ULPS decode
module lp_escape_rx
    import lp_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 4
) (
    input  logic       i_CLK_100MHZ,
    input  logic       i_reset,
    input  logic       i_lp_p,
    input  logic       i_lp_n,
    output logic [1:0] o_lp_state,
    output logic       o_stop,
    output logic       o_hs_req,
    output logic       o_lpdt,
    output logic       o_ulps,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_trigger,
    output logic [7:0] o_trig_code,
    output logic       o_eot,
    output logic       o_err_esc,
    output logic       o_err_sync,
    output logic       o_err_ctrl
);

    logic [1:0] lp_state;
    logic [1:0] lp_prev;
    logic [3:0] state;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic       line_change;
    logic       decoding;
    logic       mark_now;
    logic       rx_bit;
    logic [7:0] rx_byte;
    logic       seq_ok;
    logic [3:0] seq_next;

    lp_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYC    (FILT_CYC)
    ) u_line_filter (
        .clk   (i_CLK_100MHZ),
        .reset (i_reset),
        .line  ({i_lp_p, i_lp_n}),
        .state (lp_state)
    );

    assign o_lp_state  = lp_state;
    assign o_stop      = (state == ST_STOP);
    assign o_lpdt      = (state == ST_LPDT);
    assign o_ulps      = (state == ST_ULPS);
    assign line_change = (lp_state != lp_prev);
    assign decoding    = (state == ST_ESC_GO) || (state == ST_CMD) || (state == ST_LPDT);
    assign mark_now    = (lp_state == LP10) || (lp_state == LP01);
    // The mark that preceded the current space carries the bit value
    assign rx_bit      = (lp_prev == LP10);
    assign rx_byte     = {rx_bit, shreg};

    // Legal next hop of the request/entry handshakes for the new line state
    always_comb begin
        seq_ok   = 1'b0;
        seq_next = ST_ERR_WAIT;
        case (state)
            ST_STOP: begin
                if (lp_state == LP10) begin
                    seq_ok   = 1'b1;
                    seq_next = ST_LP_RQST;
                end else if (lp_state == LP01) begin
                    seq_ok   = 1'b1;
                    seq_next = ST_HS_RQST;
                end
            end
            ST_HS_RQST: begin
                seq_ok   = (lp_state == LP00);
                seq_next = ST_ERR_WAIT;
            end
            ST_LP_RQST: begin
                seq_ok   = (lp_state == LP00);
                seq_next = ST_LP_YIELD;
            end
            ST_LP_YIELD: begin
                seq_ok   = (lp_state == LP01);
                seq_next = ST_ESC_RQST;
            end
            ST_ESC_RQST: begin
                seq_ok   = (lp_state == LP00);
                seq_next = ST_ESC_GO;
            end
            default: begin
                seq_ok   = 1'b0;
                seq_next = ST_ERR_WAIT;
            end
        endcase
    end

    // Line-event driven protocol FSM with byte assembly and one-cycle event pulses
    always_ff @(posedge i_CLK_100MHZ) begin
        if (i_reset) begin
            state        <= ST_STOP;
            lp_prev      <= LP11;
            bit_cnt      <= '0;
            shreg        <= '0;
            o_byte       <= '0;
            o_trig_code  <= '0;
            o_hs_req     <= 1'b0;
            o_byte_valid <= 1'b0;
            o_trigger    <= 1'b0;
            o_eot        <= 1'b0;
            o_err_esc    <= 1'b0;
            o_err_sync   <= 1'b0;
            o_err_ctrl   <= 1'b0;
        end else begin
            lp_prev      <= lp_state;
            o_hs_req     <= 1'b0;
            o_byte_valid <= 1'b0;
            o_trigger    <= 1'b0;
            o_eot        <= 1'b0;
            o_err_esc    <= 1'b0;
            o_err_sync   <= 1'b0;
            o_err_ctrl   <= 1'b0;
            if (!decoding) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end
            if (line_change) begin
                case (state)
                    ST_STOP, ST_HS_RQST, ST_LP_RQST, ST_LP_YIELD, ST_ESC_RQST: begin
                        if (lp_state == LP11) begin
                            state <= ST_STOP;
                        end else if (seq_ok) begin
                            state    <= seq_next;
                            o_hs_req <= (state == ST_HS_RQST);
                        end else begin
                            o_err_ctrl <= 1'b1;
                            state      <= ST_ERR_WAIT;
                        end
                    end
                    ST_ESC_GO, ST_CMD, ST_LPDT: begin
                        if (mark_now) begin
                            if (lp_prev != LP00) begin
                                o_err_ctrl <= 1'b1;
                                state      <= ST_ERR_WAIT;
                            end else if (state == ST_ESC_GO) begin
                                state <= ST_CMD;
                            end
                        end else if (lp_state == LP00) begin
                            shreg   <= rx_byte[7:1];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (state == ST_LPDT) begin
                                    o_byte       <= rx_byte;
                                    o_byte_valid <= 1'b1;
                                end else if (rx_byte == CMD_LPDT) begin
                                    state <= ST_LPDT;
                                end else if (rx_byte == CMD_ULPS) begin
                                    state <= ST_ULPS;
                                end else if (is_trigger(rx_byte)) begin
                                    o_trig_code <= rx_byte;
                                    o_trigger   <= 1'b1;
                                    state       <= ST_TRIG_WAIT;
                                end else begin
                                    o_err_esc <= 1'b1;
                                    state     <= ST_ERR_WAIT;
                                end
                            end
                        end else begin
                            // Line returned to 11: clean only if it followed a mark on a byte boundary
                            if (lp_prev == LP00) begin
                                o_err_ctrl <= 1'b1;
                            end else if (bit_cnt == 3'd0) begin
                                o_eot <= 1'b1;
                            end else begin
                                o_err_sync <= 1'b1;
                            end
                            state <= ST_STOP;
                        end
                    end
                    ST_ULPS, ST_TRIG_WAIT: begin
                        if (lp_state == LP11) begin
                            o_eot <= 1'b1;
                            state <= ST_STOP;
                        end
                    end
                    ST_ERR_WAIT: begin
                        if (lp_state == LP11) begin
                            state <= ST_STOP;
                        end
                    end
                    default: begin
                        state <= ST_STOP;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lp_escape_rx.sv
// tb/tb_lp_escape_rx.sv - directed and randomized bench for lp_escape_rx with a line-symbol reference model
module tb_lp_escape_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       lp_p;
    logic       lp_n;
    logic [1:0] lp_state;
    logic       stop, hs_req, lpdt, ulps, byte_valid, trigger, eot;
    logic       err_esc, err_sync, err_ctrl;
    logic [7:0] rx_byte, trig_code;

    always #5 clk = ~clk;

    lp_escape_rx #(.SYNC_STAGES(2), .FILT_CYC(4)) dut (
        .i_CLK_100MHZ (clk),
        .i_reset      (rst),
        .i_lp_p       (lp_p),
        .i_lp_n       (lp_n),
        .o_lp_state   (lp_state),
        .o_stop       (stop),
        .o_hs_req     (hs_req),
        .o_lpdt       (lpdt),
        .o_ulps       (ulps),
        .o_byte       (rx_byte),
        .o_byte_valid (byte_valid),
        .o_trigger    (trigger),
        .o_trig_code  (trig_code),
        .o_eot        (eot),
        .o_err_esc    (err_esc),
        .o_err_sync   (err_sync),
        .o_err_ctrl   (err_ctrl)
    );

    localparam int EV_HS   = 1 << 8;
    localparam int EV_BYTE = 2 << 8;
    localparam int EV_TRIG = 3 << 8;
    localparam int EV_EOT  = 4 << 8;
    localparam int EV_ESC  = 5 << 8;
    localparam int EV_SYNC = 6 << 8;
    localparam int EV_CTRL = 7 << 8;

    int n_cmp = 0;
    int n_bad = 0;
    int dut_ev[$];
    int exp_ev[$];
    int multi = 0;
    int lat_bad = 0;
    logic [1:0] lp_h1 = 2'b11;
    logic [1:0] lp_h2 = 2'b11;

    // Observed pulse stream, plus pulse exclusivity and byte-latency watch
    always @(negedge clk) begin
        if (!rst) begin
            if (hs_req)   dut_ev.push_back(EV_HS);
            if (trigger)  dut_ev.push_back(EV_TRIG | int'(trig_code));
            if (eot)      dut_ev.push_back(EV_EOT);
            if (err_esc)  dut_ev.push_back(EV_ESC);
            if (err_sync) dut_ev.push_back(EV_SYNC);
            if (err_ctrl) dut_ev.push_back(EV_CTRL);
            if (byte_valid) begin
                dut_ev.push_back(EV_BYTE | int'(rx_byte));
                if (!(lp_h1 == 2'b00 && lp_h2 != 2'b00)) lat_bad++;
            end
            if ($countones({hs_req, byte_valid, trigger, eot, err_esc, err_sync, err_ctrl}) > 1) multi++;
        end
        lp_h2 = lp_h1;
        lp_h1 = lp_state;
    end

    // Reference model: consumes the sequence of distinct line symbols
    typedef enum int {M_IDLE, M_PRE, M_DEC, M_HOLD, M_WAIT} mmode_t;
    mmode_t     mm;
    bit         m_data;
    bit         m_ulps;
    logic [1:0] m_prev;
    logic [1:0] pre[$];
    int         bits[$];
    logic [1:0] esc_seq [4];

    task automatic model_reset();
        mm = M_IDLE;
        m_data = 0;
        m_ulps = 0;
        m_prev = 2'b11;
        pre.delete();
        bits.delete();
        esc_seq[0] = 2'b10; esc_seq[1] = 2'b00; esc_seq[2] = 2'b01; esc_seq[3] = 2'b00;
    endtask

    task automatic model_cmd(input int v);
        if (v == 'hE1) begin
            m_data = 1;
        end else if (v == 'h1E) begin
            mm = M_HOLD;
            m_ulps = 1;
        end else if (v == 'h62 || v == 'h5D || v == 'h21 || v == 'hA0) begin
            exp_ev.push_back(EV_TRIG | v);
            mm = M_HOLD;
            m_ulps = 0;
        end else begin
            exp_ev.push_back(EV_ESC);
            mm = M_WAIT;
        end
    endtask

    task automatic model_step(input logic [1:0] sym);
        bit esc_ok;
        bit hs_ok;
        int v;
        if (sym === m_prev) return;
        case (mm)
            M_IDLE, M_PRE: begin
                if (sym == 2'b11) begin
                    mm = M_IDLE;
                    pre.delete();
                end else begin
                    pre.push_back(sym);
                    esc_ok = 1;
                    for (int i = 0; i < pre.size(); i++) if (pre[i] != esc_seq[i]) esc_ok = 0;
                    hs_ok = (pre[0] == 2'b01) && (pre.size() == 1 || (pre.size() == 2 && pre[1] == 2'b00));
                    mm = M_PRE;
                    if (esc_ok && pre.size() == 4) begin
                        mm = M_DEC;
                        m_data = 0;
                        bits.delete();
                        pre.delete();
                    end else if (hs_ok && pre.size() == 2) begin
                        exp_ev.push_back(EV_HS);
                        mm = M_WAIT;
                        pre.delete();
                    end else if (!esc_ok && !hs_ok) begin
                        exp_ev.push_back(EV_CTRL);
                        mm = M_WAIT;
                        pre.delete();
                    end
                end
            end
            M_DEC: begin
                if (sym == 2'b11) begin
                    if (m_prev == 2'b00) exp_ev.push_back(EV_CTRL);
                    else if (bits.size() == 0) exp_ev.push_back(EV_EOT);
                    else exp_ev.push_back(EV_SYNC);
                    mm = M_IDLE;
                end else if (sym == 2'b00) begin
                    bits.push_back(m_prev == 2'b10 ? 1 : 0);
                    if (bits.size() == 8) begin
                        v = 0;
                        for (int i = 0; i < 8; i++) v += bits[i] * (1 << i);
                        bits.delete();
                        if (m_data) exp_ev.push_back(EV_BYTE | v);
                        else model_cmd(v);
                    end
                end else if (m_prev != 2'b00) begin
                    exp_ev.push_back(EV_CTRL);
                    mm = M_WAIT;
                end
            end
            M_HOLD: begin
                if (sym == 2'b11) begin
                    exp_ev.push_back(EV_EOT);
                    mm = M_IDLE;
                end
            end
            default: begin
                if (sym == 2'b11) mm = M_IDLE;
            end
        endcase
        m_prev = sym;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_events(input string tag);
        chk({tag, "_count"}, dut_ev.size(), exp_ev.size());
        for (int i = 0; i < exp_ev.size(); i++)
            chk({tag, "_event"}, (i < dut_ev.size()) ? dut_ev[i] : -1, exp_ev[i]);
        dut_ev.delete();
        exp_ev.delete();
    endtask

    task automatic send_hold(input logic [1:0] sym, input int hold);
        @(negedge clk);
        lp_p = sym[1];
        lp_n = sym[0];
        model_step(sym);
        repeat (hold) @(negedge clk);
    endtask

    task automatic send(input logic [1:0] sym);
        send_hold(sym, $urandom_range(8, 12));
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            send(b[i] ? 2'b10 : 2'b01);
            send(2'b00);
        end
    endtask

    task automatic entry();
        send(2'b10); send(2'b00); send(2'b01); send(2'b00);
    endtask

    task automatic flush();
        repeat (16) @(negedge clk);
    endtask

    int ulps_bad;
    int glitch_bad;
    int kind;
    int nb;
    int v;
    logic [1:0] g;
    logic [1:0] gp;

    initial begin
        model_reset();
        lp_p = 1'b1;
        lp_n = 1'b1;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_lp_state", lp_state, 2'b11);
        chk("rst_stop", stop, 1'b1);
        chk("rst_levels", {lpdt, ulps}, 2'b00);
        chk("rst_byte", rx_byte, 8'h00);
        chk("rst_trig_code", trig_code, 8'h00);
        chk("rst_pulses", {hs_req, byte_valid, trigger, eot, err_esc, err_sync, err_ctrl}, 7'h00);

        // LPDT with two bytes and a clean exit
        entry(); send_byte(8'hE1); flush();
        chk("lpdt_level", lpdt, 1'b1);
        send_byte(8'hA5); send_byte(8'h3C); send(2'b10); send(2'b11); flush();
        check_events("lpdt");
        chk("lpdt_stop", stop, 1'b1);

        // ULPS held for 500 cycles of 00
        entry(); send_byte(8'h1E);
        repeat (4) @(negedge clk);
        ulps_bad = 0;
        for (int i = 0; i < 490; i++) begin
            @(negedge clk);
            if (ulps !== 1'b1) ulps_bad++;
        end
        chk("ulps_held", ulps_bad, 0);
        send(2'b10); send(2'b11); flush();
        check_events("ulps");
        chk("ulps_stop", stop, 1'b1);

        // Trigger, then an unknown command
        entry(); send_byte(8'h62); flush();
        chk("trig_code", trig_code, 8'h62);
        send(2'b10); send(2'b11); flush();
        check_events("trigger");
        entry(); send_byte(8'h55); flush();
        check_events("bad_cmd");
        chk("bad_cmd_wait", {stop, lpdt, ulps}, 3'b000);
        send(2'b10); send(2'b11); flush();
        check_events("bad_cmd_exit");
        chk("bad_cmd_stop", stop, 1'b1);
        chk("trig_code_held", trig_code, 8'h62);

        // Partial LPDT byte
        entry(); send_byte(8'hE1);
        send(2'b10); send(2'b00); send(2'b01); send(2'b00); send(2'b10); send(2'b00);
        send(2'b10); send(2'b11); flush();
        check_events("partial");

        // Short glitches in STOP, then HS request
        glitch_bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            lp_p = 1'b0; lp_n = 1'b0;
            repeat (3) begin
                @(negedge clk);
                if (lp_state !== 2'b11) glitch_bad++;
            end
            lp_p = 1'b1; lp_n = 1'b1;
            repeat (8) begin
                @(negedge clk);
                if (lp_state !== 2'b11) glitch_bad++;
            end
        end
        chk("glitch_filtered", glitch_bad, 0);
        send(2'b01); send(2'b00); flush();
        check_events("hs_req");
        send(2'b11); flush();
        check_events("hs_exit");

        // Reset in the middle of LPDT with the line parked at 00
        entry(); send_byte(8'hE1); send(2'b10); send(2'b00); flush();
        check_events("pre_reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_stop", stop, 1'b1);
        chk("reset_lpdt", lpdt, 1'b0);
        model_reset();
        model_step(2'b00);
        repeat (20) @(negedge clk);
        check_events("reset_abort");
        chk("reset_err_wait", stop, 1'b0);
        send(2'b11); flush();
        chk("reset_recover", stop, 1'b1);

        // Randomized transactions
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0: begin
                    entry(); send_byte(8'hE1);
                    nb = $urandom_range(0, 3);
                    for (int i = 0; i < nb; i++) send_byte(8'($urandom));
                    send(2'b10); send(2'b11);
                end
                1: begin
                    entry(); send_byte(8'h1E); send(2'b01); send(2'b00); send(2'b10); send(2'b11);
                end
                2: begin
                    v = $urandom_range(0, 3);
                    entry();
                    send_byte(v == 0 ? 8'h62 : v == 1 ? 8'h5D : v == 2 ? 8'h21 : 8'hA0);
                    send(2'b10); send(2'b11);
                end
                3: begin
                    do v = $urandom_range(0, 255);
                    while (v == 'hE1 || v == 'h1E || v == 'h62 || v == 'h5D || v == 'h21 || v == 'hA0);
                    entry(); send_byte(8'(v)); send(2'b10); send(2'b11);
                end
                4: begin
                    entry(); send_byte(8'hE1);
                    nb = $urandom_range(1, 7);
                    for (int i = 0; i < nb; i++) begin
                        send($urandom_range(0, 1) ? 2'b10 : 2'b01);
                        send(2'b00);
                    end
                    send(2'b01); send(2'b11);
                end
                default: begin
                    gp = 2'b11;
                    nb = $urandom_range(1, 6);
                    for (int i = 0; i < nb; i++) begin
                        do g = 2'($urandom_range(0, 3));
                        while (g == gp);
                        send(g);
                        gp = g;
                    end
                    send(2'b11);
                end
            endcase
            flush();
            check_events($sformatf("rnd%0d_k%0d", t, kind));
            chk("rnd_stop", stop, (mm == M_IDLE) ? 1'b1 : 1'b0);
            chk("rnd_line", lp_state, 2'b11);
        end

        chk("pulse_exclusive", multi, 0);
        chk("byte_latency", lat_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
